// File: rtl/asic_bridge_frame_rx.sv
// asic_bridge_frame_rx
// Slave-side receiver for the bridge serial configuration frame. The serial
// lines are oversampled on CLK; a frame is a SIZESRDYN-bit dynamic word sent
// with SEL=1 followed by a SIZESRSTAT-bit static word sent with SEL=0, both MSB
// first. Completed words are presented in parallel with one-cycle valid pulses.
// Malformed or stalled frames produce a one-cycle FRAME_ERR pulse.

module asic_bridge_frame_rx #(
  parameter int SIZESRDYN      = 16,
  parameter int SIZESRSTAT     = 88,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCLK_IN,
  input  logic                  SEL,
  input  logic                  MOSI,
  output logic [SIZESRDYN-1:0]  DYN_DATA,
  output logic [SIZESRSTAT-1:0] STAT_DATA,
  output logic                  DYN_VALID,
  output logic                  STAT_VALID,
  output logic                  FRAME_ERR,
  output logic                  BUSY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DYN  = 2'd1;
  localparam logic [1:0] ST_STAT = 2'd2;

  localparam logic [6:0]    LAST_DYN  = 7'(SIZESRDYN - 1);
  localparam logic [6:0]    LAST_STAT = 7'(SIZESRSTAT - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Synchronizer stages
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sel_s1_q, sel_s2_q;
  logic mosi_s1_q, mosi_s2_q;
  logic sclk_edge;

  // Frame state
  logic [1:0]            state_q, state_d;
  logic [6:0]            bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         tout_cnt_q, tout_cnt_d;
  logic [SIZESRDYN-1:0]  dyn_sr_q, dyn_sr_d, dyn_shift;
  logic [SIZESRSTAT-1:0] stat_sr_q, stat_sr_d, stat_shift;
  logic [SIZESRDYN-1:0]  dyn_data_q, dyn_data_d;
  logic [SIZESRSTAT-1:0] stat_data_q, stat_data_d;
  logic                  dyn_valid_q, dyn_valid_d;
  logic                  stat_valid_q, stat_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  go_idle;

  assign sclk_edge  = sclk_s2_q & ~sclk_s3_q;
  assign dyn_shift  = {dyn_sr_q[SIZESRDYN-2:0], mosi_s2_q};
  assign stat_shift = {stat_sr_q[SIZESRSTAT-2:0], mosi_s2_q};

  // Bring the asynchronous serial lines into the CLK domain
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      sel_s1_q  <= 1'b0;
      sel_s2_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= SCLK_IN;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      sel_s1_q  <= SEL;
      sel_s2_q  <= sel_s1_q;
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // Frame FSM: shift on serial edges, publish words, detect aborts and stalls
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    dyn_sr_d     = dyn_sr_q;
    stat_sr_d    = stat_sr_q;
    dyn_data_d   = dyn_data_q;
    stat_data_d  = stat_data_q;
    dyn_valid_d  = 1'b0;
    stat_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    go_idle      = 1'b0;

    if (state_q == ST_IDLE || sclk_edge) tout_cnt_d = '0;
    else                                 tout_cnt_d = tout_cnt_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        // An edge with SEL low while idle is a stray clock and is ignored.
        if (sclk_edge && sel_s2_q) begin
          dyn_sr_d  = dyn_shift;
          bit_cnt_d = 7'd1;
          state_d   = ST_DYN;
        end
      end
      ST_DYN: begin
        if (sclk_edge) begin
          if (!sel_s2_q) begin
            frame_err_d = 1'b1;
            go_idle     = 1'b1;
          end else if (bit_cnt_q == LAST_DYN) begin
            dyn_sr_d    = dyn_shift;
            dyn_data_d  = dyn_shift;
            dyn_valid_d = 1'b1;
            bit_cnt_d   = 7'd0;
            state_d     = ST_STAT;
          end else begin
            dyn_sr_d  = dyn_shift;
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else if (tout_cnt_q == TOUT_LAST) begin
          frame_err_d = 1'b1;
          go_idle     = 1'b1;
        end
      end
      ST_STAT: begin
        if (sclk_edge) begin
          // SEL high here aborts the frame; it does not start a new one.
          if (sel_s2_q) begin
            frame_err_d = 1'b1;
            go_idle     = 1'b1;
          end else if (bit_cnt_q == LAST_STAT) begin
            stat_data_d  = stat_shift;
            stat_valid_d = 1'b1;
            go_idle      = 1'b1;
          end else begin
            stat_sr_d = stat_shift;
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else if (tout_cnt_q == TOUT_LAST) begin
          frame_err_d = 1'b1;
          go_idle     = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 7'd0;
      dyn_sr_d   = '0;
      stat_sr_d  = '0;
      tout_cnt_d = '0;
    end
  end

  // FSM, shift-register and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 7'd0;
      tout_cnt_q   <= '0;
      dyn_sr_q     <= '0;
      stat_sr_q    <= '0;
      dyn_data_q   <= '0;
      stat_data_q  <= '0;
      dyn_valid_q  <= 1'b0;
      stat_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tout_cnt_q   <= tout_cnt_d;
      dyn_sr_q     <= dyn_sr_d;
      stat_sr_q    <= stat_sr_d;
      dyn_data_q   <= dyn_data_d;
      stat_data_q  <= stat_data_d;
      dyn_valid_q  <= dyn_valid_d;
      stat_valid_q <= stat_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign DYN_DATA   = dyn_data_q;
  assign STAT_DATA  = stat_data_q;
  assign DYN_VALID  = dyn_valid_q;
  assign STAT_VALID = stat_valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_asic_bridge_frame_rx.sv
// Testbench for asic_bridge_frame_rx: directed frames driven with SCLK = CLK/8,
// pulse counters sampled just after each CLK edge, data checked against
// hand-computed constants.

module tb_asic_bridge_frame_rx;

  localparam int DYNW  = 16;
  localparam int STATW = 88;
  localparam int TOUT  = 4096;

  localparam logic [DYNW-1:0]  DYN1  = 16'hABC6;
  localparam logic [DYNW-1:0]  DYN2  = 16'h5A5A;
  localparam logic [DYNW-1:0]  DYN3  = 16'h1234;
  localparam logic [STATW-1:0] STAT1 = 88'h123456789ABCDEF1234567;
  localparam logic [STATW-1:0] STAT2 = 88'hEDCBA9876543210EDCBA98;
  localparam logic [STATW-1:0] STAT3 = 88'hFEDCBA9876543210FEDCBA;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             SCLK_IN = 1'b0;
  logic             SEL = 1'b0;
  logic             MOSI = 1'b0;
  logic [DYNW-1:0]  DYN_DATA;
  logic [STATW-1:0] STAT_DATA;
  logic             DYN_VALID, STAT_VALID, FRAME_ERR, BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  int dyn_cnt = 0, stat_cnt = 0, err_cnt = 0, overlap_cnt = 0;

  asic_bridge_frame_rx #(
    .SIZESRDYN(DYNW), .SIZESRSTAT(STATW), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .SCLK_IN(SCLK_IN), .SEL(SEL), .MOSI(MOSI),
    .DYN_DATA(DYN_DATA), .STAT_DATA(STAT_DATA), .DYN_VALID(DYN_VALID),
    .STAT_VALID(STAT_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Count output pulses once per cycle, just after the active edge.
  always @(posedge CLK) begin
    #1;
    if (!RST) begin
      if (DYN_VALID)  dyn_cnt++;
      if (STAT_VALID) stat_cnt++;
      if (FRAME_ERR)  err_cnt++;
      if (int'(DYN_VALID) + int'(STAT_VALID) + int'(FRAME_ERR) > 1) overlap_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One serial bit: 4 CLK low with data set up, then 4 CLK high.
  task automatic send_bit(input logic sel_v, input logic b);
    @(negedge CLK);
    SCLK_IN = 1'b0;
    SEL     = sel_v;
    MOSI    = b;
    repeat (4) @(negedge CLK);
    SCLK_IN = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [DYNW-1:0] d, input logic [STATW-1:0] s);
    for (int i = DYNW - 1; i >= 0; i--) send_bit(1'b1, d[i]);
    for (int i = STATW - 1; i >= 0; i--) send_bit(1'b0, s[i]);
    @(negedge CLK);
    SCLK_IN = 1'b0;
    SEL     = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    int first_err;

    // Reset state
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_dyn_data", DYN_DATA, '0);
    check("reset_stat_data", STAT_DATA, '0);
    check("reset_pulses", {DYN_VALID, STAT_VALID, FRAME_ERR}, 3'b000);
    check("reset_busy", BUSY, 1'b0);

    // SEL drops after 10 dynamic bits
    for (int i = DYNW - 1; i >= DYNW - 10; i--) send_bit(1'b1, DYN1[i]);
    check("abort_busy_mid", BUSY, 1'b1);
    send_bit(1'b0, 1'b0);
    @(negedge CLK);
    SCLK_IN = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort_err_cnt", err_cnt, 1);
    check("abort_dyn_data", DYN_DATA, 16'h0000);
    check("abort_busy", BUSY, 1'b0);

    // Full frame after the abort
    send_frame(DYN1, STAT1);
    check("f1_dyn_cnt", dyn_cnt, 1);
    check("f1_stat_cnt", stat_cnt, 1);
    check("f1_dyn_data", DYN_DATA, DYN1);
    check("f1_stat_data", STAT_DATA, STAT1);
    check("f1_busy", BUSY, 1'b0);

    // Serial clock stops after 40 static bits
    for (int i = DYNW - 1; i >= 0; i--) send_bit(1'b1, DYN1[i]);
    for (int i = STATW - 1; i >= STATW - 39; i--) send_bit(1'b0, STAT2[i]);
    @(negedge CLK);
    SCLK_IN = 1'b0;
    SEL     = 1'b0;
    MOSI    = STAT2[STATW-40];
    repeat (4) @(negedge CLK);
    SCLK_IN = 1'b1;
    first_err = 0;
    for (int k = 1; k <= TOUT + 200; k++) begin
      @(negedge CLK);
      if (k == 4) SCLK_IN = 1'b0;
      if (FRAME_ERR && first_err == 0) first_err = k;
    end
    // Edge registered 3 CLKs after SCLK rises; abort TOUT CLKs after that.
    check("tout_latency", first_err, TOUT + 3);
    check("tout_err_cnt", err_cnt, 2);
    check("tout_dyn_cnt", dyn_cnt, 2);
    check("tout_stat_cnt", stat_cnt, 1);
    check("tout_dyn_data", DYN_DATA, DYN1);
    check("tout_stat_data", STAT_DATA, STAT1);
    check("tout_busy", BUSY, 1'b0);

    // Stray serial clocks with SEL low while idle
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 1'b1);
      check("stray_busy", BUSY, 1'b0);
    end
    @(negedge CLK);
    SCLK_IN = 1'b0;
    repeat (4) @(negedge CLK);
    check("stray_counts", {dyn_cnt[7:0], stat_cnt[7:0], err_cnt[7:0]}, {8'd2, 8'd1, 8'd2});
    check("stray_dyn_data", DYN_DATA, DYN1);
    check("stray_stat_data", STAT_DATA, STAT1);

    // Reset during static bit 50
    for (int i = DYNW - 1; i >= 0; i--) send_bit(1'b1, DYN2[i]);
    for (int i = STATW - 1; i >= STATW - 49; i--) send_bit(1'b0, STAT3[i]);
    @(negedge CLK);
    SCLK_IN = 1'b0;
    MOSI    = STAT3[STATW-50];
    repeat (2) @(negedge CLK);
    check("rst_pre_busy", BUSY, 1'b1);
    check("rst_pre_dyn_data", DYN_DATA, DYN2);
    RST = 1'b1;
    #1;
    check("rst_mid_dyn_data", DYN_DATA, '0);
    check("rst_mid_stat_data", STAT_DATA, '0);
    check("rst_mid_busy", BUSY, 1'b0);
    check("rst_mid_pulses", {DYN_VALID, STAT_VALID, FRAME_ERR}, 3'b000);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    send_frame(DYN3, STAT3);
    check("rst_f_dyn_data", DYN_DATA, DYN3);
    check("rst_f_stat_data", STAT_DATA, STAT3);
    check("rst_f_counts", {dyn_cnt[7:0], stat_cnt[7:0], err_cnt[7:0]}, {8'd4, 8'd2, 8'd2});

    // Back-to-back frames with one SCLK period gap
    send_frame(DYN1, STAT1);
    check("b2b_1_dyn_data", DYN_DATA, DYN1);
    check("b2b_1_stat_data", STAT_DATA, STAT1);
    send_frame(DYN2, STAT2);
    check("b2b_2_dyn_data", DYN_DATA, DYN2);
    check("b2b_2_stat_data", STAT_DATA, STAT2);
    check("b2b_dyn_cnt", dyn_cnt, 6);
    check("b2b_stat_cnt", stat_cnt, 4);
    check("b2b_err_cnt", err_cnt, 2);
    check("pulse_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
